// File: rtl/mem_stage_if.sv
// EX-to-MEM pipeline bundle plus the MEM-stage results (forwarding and writeback).
// The slave side is the memory stage; the master side is the pipeline around it.
// Timing contract: stall/flush and every *_ex signal are sampled on the rising
// edge of clk; all outputs are registered or come from registers only, so they
// are stable for the whole cycle after each edge.
interface mem_stage_if;
    logic        stall;
    logic        flush;
    logic        valid_ex;
    logic [31:0] alu_out_ex;
    logic [31:0] store_data_ex;
    logic [31:0] pc_ex;
    logic [4:0]  write_num_ex;
    logic        RegWrite_ex;
    logic        MemRead_ex;
    logic        MemWrite_ex;
    logic        MemtoReg_ex;
    logic        JalSrc_ex;
    logic [1:0]  MemSize_ex;
    logic        MemUnsigned_ex;

    logic        fwd_mem_en;
    logic [4:0]  fwd_mem_num;
    logic [31:0] fwd_mem_data;
    logic        mem_is_load;
    logic        write_en_wb;
    logic [4:0]  write_num_wb;
    logic [31:0] write_data_wb;
    logic        misalign_wb;

    modport slave (
        input  stall, flush, valid_ex, alu_out_ex, store_data_ex, pc_ex, write_num_ex,
               RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, JalSrc_ex,
               MemSize_ex, MemUnsigned_ex,
        output fwd_mem_en, fwd_mem_num, fwd_mem_data, mem_is_load,
               write_en_wb, write_num_wb, write_data_wb, misalign_wb
    );

    modport master (
        output stall, flush, valid_ex, alu_out_ex, store_data_ex, pc_ex, write_num_ex,
               RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, JalSrc_ex,
               MemSize_ex, MemUnsigned_ex,
        input  fwd_mem_en, fwd_mem_num, fwd_mem_data, mem_is_load,
               write_en_wb, write_num_wb, write_data_wb, misalign_wb
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, byte-addressable data RAM with
// byte/half/word load-store, MEM/WB register, and MEM forwarding outputs.
module mem_stage #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // EX/MEM pipeline register
    logic        m_valid;
    logic [31:0] m_alu;
    logic [31:0] m_store;
    logic [31:0] m_pc;
    logic [4:0]  m_num;
    logic        m_regwrite;
    logic        m_memread;
    logic        m_memwrite;
    logic        m_memtoreg;
    logic        m_jal;
    logic [1:0]  m_size;
    logic        m_unsigned;

    // Data RAM, one 32-bit word per entry, little-endian lanes
    logic [31:0] ram [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]  lane;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        store_en;
    logic [3:0]  byte_en;
    logic [31:0] store_word;
    logic [31:0] rd_word;
    logic [31:0] rd_shifted;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [31:0] pc_plus4;
    logic [31:0] result;
    logic        wb_en_next;
    logic        wb_mis_next;

    // EX/MEM capture: reset and flush insert a bubble, stall holds
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            m_valid    <= 1'b0;
            m_alu      <= '0;
            m_store    <= '0;
            m_pc       <= '0;
            m_num      <= '0;
            m_regwrite <= 1'b0;
            m_memread  <= 1'b0;
            m_memwrite <= 1'b0;
            m_memtoreg <= 1'b0;
            m_jal      <= 1'b0;
            m_size     <= '0;
            m_unsigned <= 1'b0;
        end else if (!bus.stall) begin
            m_valid    <= bus.valid_ex;
            m_alu      <= bus.alu_out_ex;
            m_store    <= bus.store_data_ex;
            m_pc       <= bus.pc_ex;
            m_num      <= bus.write_num_ex;
            m_regwrite <= bus.RegWrite_ex;
            m_memread  <= bus.MemRead_ex;
            m_memwrite <= bus.MemWrite_ex;
            m_memtoreg <= bus.MemtoReg_ex;
            m_jal      <= bus.JalSrc_ex;
            m_size     <= bus.MemSize_ex;
            m_unsigned <= bus.MemUnsigned_ex;
        end
    end

    // Address decode, alignment, store lane enables and load extraction
    always_comb begin
        word_idx   = m_alu[ADDR_WIDTH+1:2];
        lane       = m_alu[1:0];
        is_byte    = (m_size == 2'b00);
        is_half    = (m_size == 2'b01);
        is_word    = m_size[1];
        misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));
        store_en   = m_valid && m_memwrite && !misaligned && !bus.stall;

        byte_en    = 4'b1111;
        store_word = m_store;
        if (is_byte) begin
            byte_en    = 4'b0001 << lane;
            store_word = {4{m_store[7:0]}};
        end else if (is_half) begin
            byte_en    = lane[1] ? 4'b1100 : 4'b0011;
            store_word = {2{m_store[15:0]}};
        end

        rd_word    = ram[word_idx];
        rd_shifted = rd_word >> {lane, 3'b000};
        rd_half    = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data  = rd_word;
        if (is_byte) begin
            load_data = m_unsigned ? {24'd0, rd_shifted[7:0]}
                                   : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
        end else if (is_half) begin
            load_data = m_unsigned ? {16'd0, rd_half}
                                   : {{16{rd_half[15]}}, rd_half};
        end

        pc_plus4    = m_pc + 32'd4;
        result      = m_jal ? pc_plus4 : (m_memtoreg ? load_data : m_alu);
        wb_en_next  = m_valid && m_regwrite && (m_num != 5'd0) && !(m_memread && misaligned);
        wb_mis_next = m_valid && (m_memread || m_memwrite) && misaligned;
    end

    // RAM write; held stores write only on the edge they leave MEM, reset blocks writes
    always_ff @(posedge clk) begin
        if (!rst && store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    ram[word_idx][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

    // MEM/WB capture: reset clears, stall holds
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.write_en_wb   <= 1'b0;
            bus.write_num_wb  <= '0;
            bus.write_data_wb <= '0;
            bus.misalign_wb   <= 1'b0;
        end else if (!bus.stall) begin
            bus.write_en_wb   <= wb_en_next;
            bus.write_num_wb  <= m_num;
            bus.write_data_wb <= result;
            bus.misalign_wb   <= wb_mis_next;
        end
    end

    // Forwarding and load-use information straight from EX/MEM
    always_comb begin
        bus.fwd_mem_en   = m_valid && m_regwrite && (m_num != 5'd0) && !m_memread;
        bus.fwd_mem_num  = m_num;
        bus.fwd_mem_data = m_jal ? pc_plus4 : m_alu;
        bus.mem_is_load  = m_valid && m_memread && (m_num != 5'd0);
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: drivers push expected forwarding and writeback
// values with the cycle they are due; a monitor pops and compares at negedge.
module tb_mem_stage;

    localparam int W = 56; // {due[15:0], chk, en, num[4:0], data[31:0], flag}

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] cyc = 16'd0;
    int checks = 0;
    int errors = 0;

    logic [W-1:0] fwd_q[$];
    logic [W-1:0] wb_q[$];
    logic [39:0]  cur_fwd;
    logic [39:0]  cur_wb;
    logic [39:0]  held_wb;

    mem_stage_if bus ();

    mem_stage #(.ADDR_WIDTH(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 16'd1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [39:0] body(input logic chk, input logic en, input logic [4:0] num,
                                         input logic [31:0] data, input logic flag);
        return {chk, en, num, data, flag};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                          input logic [31:0] pc, input logic [4:0] num, input logic rw,
                          input logic mr, input logic mw, input logic m2r, input logic jal,
                          input logic [1:0] sz, input logic us);
        bus.valid_ex = v;       bus.alu_out_ex = alu;   bus.store_data_ex = sd;
        bus.pc_ex = pc;         bus.write_num_ex = num; bus.RegWrite_ex = rw;
        bus.MemRead_ex = mr;    bus.MemWrite_ex = mw;   bus.MemtoReg_ex = m2r;
        bus.JalSrc_ex = jal;    bus.MemSize_ex = sz;    bus.MemUnsigned_ex = us;
    endtask

    function automatic logic mis_of(input logic [31:0] addr, input logic [1:0] sz);
        return (sz == 2'b01 && addr[0]) || (sz[1] && addr[1:0] != 2'b00);
    endfunction

    task automatic op_nop();
        set_ex(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        cur_fwd = body(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        cur_wb  = body(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic op_load(input logic [31:0] addr, input logic [4:0] rd, input logic [1:0] sz,
                           input logic us, input logic [31:0] exp_data);
        logic m;
        m = mis_of(addr, sz);
        set_ex(1'b1, addr, 32'h0BAD_0BAD, 32'h0000_1000, rd, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, sz, us);
        cur_fwd = body(1'b1, 1'b0, rd, addr, rd != 5'd0);
        cur_wb  = body(!m, (rd != 5'd0) && !m, rd, exp_data, m);
    endtask

    task automatic op_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
        logic m;
        m = mis_of(addr, sz);
        set_ex(1'b1, addr, data, 32'h0000_1000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, sz, 1'b0);
        cur_fwd = body(1'b1, 1'b0, 5'd0, addr, 1'b0);
        cur_wb  = body(1'b1, 1'b0, 5'd0, addr, m);
    endtask

    task automatic op_alu(input logic [4:0] rd, input logic [31:0] val);
        set_ex(1'b1, val, 32'd0, 32'h0000_1000, rd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        cur_fwd = body(1'b1, rd != 5'd0, rd, val, 1'b0);
        cur_wb  = body(1'b1, rd != 5'd0, rd, val, 1'b0);
    endtask

    task automatic op_jal(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] exp_link);
        set_ex(1'b1, 32'hDEAD_0000, 32'd0, pc, rd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
        cur_fwd = body(1'b1, 1'b1, rd, exp_link, 1'b0);
        cur_wb  = body(1'b1, 1'b1, rd, exp_link, 1'b0);
    endtask

    task automatic step_normal();
        fwd_q.push_back({cyc + 16'd1, cur_fwd});
        wb_q.push_back({cyc + 16'd2, cur_wb});
        @(negedge clk);
    endtask

    task automatic step_fwd_only();
        fwd_q.push_back({cyc + 16'd1, cur_fwd});
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        op_nop();
        rst = 1'b1;
        fwd_q.push_back({cyc + 16'd1, body(1'b1, 1'b0, 5'd0, 32'd0, 1'b0)});
        wb_q.push_back({cyc + 16'd1, body(1'b1, 1'b0, 5'd0, 32'd0, 1'b0)});
        wb_q.push_back({cyc + 16'd2, body(1'b1, 1'b0, 5'd0, 32'd0, 1'b0)});
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string name, input logic [31:0] act);
        checks++;
        if (act !== 32'd0) begin
            errors++;
            $display("FAIL reset_%s: got %h, expected 00000000", name, act);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic bad;
        if (wb_q.size() > 0 && wb_q[0][55:40] <= cyc) begin
            e = wb_q.pop_front();
            checks++;
            bad = (e[55:40] != cyc) || (bus.write_en_wb !== e[38]) || (bus.misalign_wb !== e[0]) ||
                  (e[39] && ((bus.write_num_wb !== e[37:33]) || (bus.write_data_wb !== e[32:1])));
            if (bad) begin
                errors++;
                $display("FAIL wb@%0d: got en=%b num=%0d data=%h mis=%b, expected en=%b num=%0d data=%h mis=%b (chk=%b due=%0d)",
                         cyc, bus.write_en_wb, bus.write_num_wb, bus.write_data_wb, bus.misalign_wb,
                         e[38], e[37:33], e[32:1], e[0], e[39], e[55:40]);
            end
        end
        if (fwd_q.size() > 0 && fwd_q[0][55:40] <= cyc) begin
            e = fwd_q.pop_front();
            checks++;
            bad = (e[55:40] != cyc) || (bus.fwd_mem_en !== e[38]) || (bus.mem_is_load !== e[0]) ||
                  (e[39] && ((bus.fwd_mem_num !== e[37:33]) || (bus.fwd_mem_data !== e[32:1])));
            if (bad) begin
                errors++;
                $display("FAIL fwd@%0d: got en=%b num=%0d data=%h load=%b, expected en=%b num=%0d data=%h load=%b (chk=%b due=%0d)",
                         cyc, bus.fwd_mem_en, bus.fwd_mem_num, bus.fwd_mem_data, bus.mem_is_load,
                         e[38], e[37:33], e[32:1], e[0], e[39], e[55:40]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        op_nop();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("write_en_wb",   {31'd0, bus.write_en_wb});
        check_zero("write_num_wb",  {27'd0, bus.write_num_wb});
        check_zero("write_data_wb", bus.write_data_wb);
        check_zero("misalign_wb",   {31'd0, bus.misalign_wb});
        check_zero("fwd_mem_en",    {31'd0, bus.fwd_mem_en});
        check_zero("mem_is_load",   {31'd0, bus.mem_is_load});
        check_zero("fwd_mem_num",   {27'd0, bus.fwd_mem_num});
        check_zero("fwd_mem_data",  bus.fwd_mem_data);
        rst = 1'b0;

        // word, byte and halfword traffic
        op_store(32'h20, 32'h0000_0000, 2'b10);         step_normal();
        op_store(32'h10, 32'hDEAD_BEEF, 2'b10);         step_normal();
        op_load (32'h10, 5'd8,  2'b10, 1'b0, 32'hDEAD_BEEF); step_normal();
        op_store(32'h13, 32'h1234_5680, 2'b00);         step_normal();
        op_load (32'h13, 5'd9,  2'b00, 1'b0, 32'hFFFF_FF80); step_normal();
        op_load (32'h13, 5'd10, 2'b00, 1'b1, 32'h0000_0080); step_normal();
        op_load (32'h10, 5'd11, 2'b10, 1'b0, 32'h80AD_BEEF); step_normal();
        op_load (32'h12, 5'd12, 2'b01, 1'b0, 32'hFFFF_80AD); step_normal();
        op_load (32'h12, 5'd13, 2'b01, 1'b1, 32'h0000_80AD); step_normal();
        op_load (32'h10, 5'd14, 2'b00, 1'b1, 32'h0000_00EF); step_normal();
        op_load (32'h11, 5'd15, 2'b00, 1'b0, 32'hFFFF_FFBE); step_normal();
        op_store(32'h22, 32'hABCD_1234, 2'b01);         step_normal();
        op_load (32'h20, 5'd16, 2'b10, 1'b0, 32'h1234_0000); step_normal();
        op_load (32'h21, 5'd17, 2'b01, 1'b0, 32'h0000_0000); step_normal();
        op_store(32'h22, 32'hFFFF_FFFF, 2'b10);         step_normal();
        op_load (32'h20, 5'd18, 2'b10, 1'b0, 32'h1234_0000); step_normal();
        op_load (32'h22, 5'd19, 2'b01, 1'b0, 32'h0000_1234); step_normal();
        op_load (32'h23, 5'd20, 2'b11, 1'b0, 32'h0000_0000); step_normal();

        // jal link values, r0 suppression, address wrap
        op_jal(32'h0000_3000, 5'd31, 32'h0000_3004);    step_normal();
        op_jal(32'hFFFF_FFFC, 5'd31, 32'h0000_0000);    step_normal();
        op_alu(5'd0, 32'h0000_0005);                    step_normal();
        op_alu(5'd3, 32'h0000_0055);                    step_normal();
        op_load (32'h10, 5'd0, 2'b10, 1'b0, 32'h80AD_BEEF); step_normal();
        op_store(32'h0000_1040, 32'h5A5A_5A5A, 2'b10);  step_normal();
        op_load (32'h40, 5'd21, 2'b10, 1'b0, 32'h5A5A_5A5A); step_normal();

        // store held in MEM by a 3-cycle stall
        op_alu(5'd22, 32'h0000_0077);                   step_normal();
        held_wb = cur_wb;
        op_store(32'h30, 32'hCAFE_F00D, 2'b10);         step_fwd_only();
        cur_wb = body(1'b1, 1'b0, 5'd0, 32'h30, 1'b0);
        begin
            logic [39:0] sw_fwd;
            logic [39:0] sw_wb;
            sw_fwd = body(1'b1, 1'b0, 5'd0, 32'h30, 1'b0);
            sw_wb  = cur_wb;
            op_load(32'h30, 5'd5, 2'b10, 1'b0, 32'hCAFE_F00D);
            bus.stall = 1'b1;
            for (int i = 0; i < 3; i++) begin
                fwd_q.push_back({cyc + 16'd1, sw_fwd});
                wb_q.push_back({cyc + 16'd1, held_wb});
                @(negedge clk);
            end
            bus.stall = 1'b0;
            fwd_q.push_back({cyc + 16'd1, cur_fwd});
            wb_q.push_back({cyc + 16'd1, sw_wb});
            wb_q.push_back({cyc + 16'd2, cur_wb});
            @(negedge clk);
        end
        op_load(32'h30, 5'd6, 2'b10, 1'b0, 32'hCAFE_F00D); step_normal();

        // stall and flush together drop the store sitting in MEM
        op_store(32'h34, 32'h2222_2222, 2'b10);         step_normal();
        op_alu(5'd23, 32'h0000_0088);                   step_normal();
        held_wb = cur_wb;
        op_store(32'h34, 32'h1111_1111, 2'b10);         step_fwd_only();
        op_nop();
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        fwd_q.push_back({cyc + 16'd1, body(1'b0, 1'b0, 5'd0, 32'd0, 1'b0)});
        wb_q.push_back({cyc + 16'd1, held_wb});
        @(negedge clk);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        wb_q.push_back({cyc + 16'd1, body(1'b0, 1'b0, 5'd0, 32'd0, 1'b0)});
        op_load(32'h34, 5'd7, 2'b10, 1'b0, 32'h2222_2222); step_normal();

        // flush alone turns the EX instruction into a bubble
        op_alu(5'd24, 32'h0000_0099);                   step_normal();
        op_alu(5'd25, 32'h0000_00AA);
        bus.flush = 1'b1;
        cur_fwd = body(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        cur_wb  = body(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        step_normal();
        bus.flush = 1'b0;

        // reset while a store is in MEM: no write happens
        op_store(32'h10, 32'h9999_9999, 2'b10);         step_fwd_only();
        reset_pulse();
        op_load(32'h10, 5'd26, 2'b10, 1'b0, 32'h80AD_BEEF); step_normal();

        // reset with a valid load in EX/MEM
        op_load(32'h10, 5'd27, 2'b10, 1'b0, 32'h80AD_BEEF); step_fwd_only();
        reset_pulse();

        // drain
        op_nop();
        for (int i = 0; i < 20 && (wb_q.size() > 0 || fwd_q.size() > 0); i++) begin
            @(negedge clk);
        end
        if (wb_q.size() > 0 || fwd_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d wb and %0d fwd expectations left, expected 0",
                     wb_q.size(), fwd_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage MIPS pipeline, downstream of EX: holds the EX/MEM pipeline register, the data RAM with byte/halfword/word load-store, and the MEM/WB pipeline register. It drives the register-file write port (write_num, write_en, write_data) consumed by ID. It also exports MEM-stage destination information for forwarding and load-use detection.

## Interface
- ADDR_WIDTH, 10, log2 of data RAM depth in 32-bit words
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold EX/MEM and MEM/WB contents
- flush  in  1  load a bubble into EX/MEM instead of EX outputs
- valid_ex  in  1  EX slot holds a real instruction
- alu_out_ex  in  32  ALU result / effective address
- store_data_ex  in  32  rt value for stores
- pc_ex  in  32  PC of the EX instruction
- write_num_ex  in  5  destination register, already RegDst/JalSrc-resolved
- RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, JalSrc_ex  in  1 each  control bits
- MemSize_ex  in  2  00 byte, 01 half, 10 word (11 treated as word)
- MemUnsigned_ex  in  1  zero-extend loads (lbu/lhu)
- fwd_mem_en  out  1  MEM instruction will write a non-zero register
- fwd_mem_num  out  5  its destination
- fwd_mem_data  out  32  its ALU result, or PC+4 for jal
- mem_is_load  out  1  MEM instruction is a valid load (hazard unit stalls on match)
- write_en_wb  out  1  register-file write enable
- write_num_wb  out  5  register-file write address
- write_data_wb  out  32  register-file write data
- misalign_wb  out  1  WB instruction had a misaligned access

## Operation
- EX/MEM register captures all *_ex inputs on posedge.
  - rst: valid cleared, all control bits cleared.
  - flush (priority over stall): valid=0, control bits cleared.
  - stall (without flush): hold.
- Address decode: word index = alu_out[ADDR_WIDTH+1:2]; upper address bits are ignored and wrap. Lane = alu_out[1:0], little-endian.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0. A misaligned store is suppressed. A misaligned load reaches WB with write_en_wb=0 and misalign_wb=1.
- Store: RAM written on posedge when valid & MemWrite & !misaligned & !stall. Byte lane writes data[7:0] to lane; half writes data[15:0] to lanes {addr[1],0}+1..+0; word writes all lanes. A stalled store writes exactly once, on the cycle it leaves MEM.
- Load: combinational read of the addressed word, lane-selected, then sign- or zero-extended per MemUnsigned.
- Result select: JalSrc → pc+4 (32-bit wrap); else MemtoReg → extended load data; else alu_out.
- MEM/WB register captures result, write_num, write_en = valid & RegWrite & (num≠0) & !misaligned-load, and misalign.
  - rst clears the register.
  - stall holds it.
- Forwarding outputs are combinational from EX/MEM.
  - fwd_mem_en = valid & RegWrite & num≠0 & !MemRead.
  - mem_is_load = valid & MemRead & num≠0.
- RAM contents are not cleared by rst; simulation initial value is 0.

## Timing
- Reset values: write_en_wb=0, write_num_wb=0, write_data_wb=0, misalign_wb=0, fwd_mem_en=0, mem_is_load=0, fwd_mem_num=0, fwd_mem_data=0.
- Latency: EX inputs at edge N appear on fwd_* during cycle N+1 and on *_wb during cycle N+2.
- The regfile writes on edge N+2; ID reads the new value from cycle N+2 (regfile write-before-read).
- Store followed by a load to the same word in the next instruction: the load sees the new data (write at edge, read in the following cycle).
- rst asserted mid-stall or mid-store: rst wins; no RAM write occurs on that edge.
- stall and flush together: EX/MEM becomes a bubble and MEM/WB holds. The instruction that was in MEM is dropped and not written back, so the hazard unit must never assert both for a live MEM instruction.

## Test plan
- sw 0xDEADBEEF to 0x10, then lw from 0x10 to r8 → write_en_wb=1, write_num_wb=8, write_data_wb=0xDEADBEEF.
- Byte loads from that word:
  - sb 0x80 to 0x13, then lb from 0x13 → 0xFFFFFF80.
  - lbu from 0x13 → 0x00000080.
  - lw from 0x10 → 0x80ADBEEF.
- Halfword accesses:
  - sh 0x1234 to 0x22, then lw from 0x20 → 0x12340000.
  - lh from 0x21 (misaligned) → write_en_wb=0, misalign_wb=1, RAM unchanged.
- jal at pc 0x00003000 with write_num 31 → write_data_wb=0x00003004; fwd_mem_data=0x00003004 one cycle earlier.
- Stall during store (stall high 3 cycles) → RAM written once; MEM/WB holds; add to r0 → write_en_wb=0.
- rst pulse with a valid lw in EX/MEM → all outputs return to 0 the next cycle; flush → bubble (fwd_mem_en=0).
